// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Round-robin, burst-bounded arbiter that shares dm_4k between
//               the CPU datapath (M0) and a loader/DMA port (M1).
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [3:0]    be0,
    input  logic [DW-1:0] wd0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [3:0]    be1,
    input  logic [DW-1:0] wd1,
    output logic          ack0,
    output logic          ack1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [DW-1:0] dm_wd,
    output logic          dm_we,
    input  logic [DW-1:0] dm_rd
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_g0     = 2'd1;
    localparam logic [1:0] c_st_g1     = 2'd2;
    localparam logic [4:0] c_max_burst = 5'(MAX_BURST);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic          r_last;       // 1 = M1 held the most recent grant
    logic [3:0]    r_beat_cnt;
    logic [4:0]    w_cnt_inc;
    logic          w_beat0;
    logic          w_beat1;
    logic [DW-1:0] r_rdata;
    logic          r_rvalid0;
    logic          r_rvalid1;

    assign w_beat0   = (r_state == c_st_g0) && req0;
    assign w_beat1   = (r_state == c_st_g1) && req1;
    assign w_cnt_inc = {1'b0, r_beat_cnt} + 5'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE is always a one-cycle turnaround between grants
    always_comb begin
        w_next_state = c_st_idle;
        case (r_state)
            c_st_idle: begin
                if (req0 && req1)  w_next_state = r_last ? c_st_g0 : c_st_g1;
                else if (req0)     w_next_state = c_st_g0;
                else if (req1)     w_next_state = c_st_g1;
                else               w_next_state = c_st_idle;
            end
            c_st_g0: begin
                if (req0 && (w_cnt_inc < c_max_burst)) w_next_state = c_st_g0;
            end
            c_st_g1: begin
                if (req1 && (w_cnt_inc < c_max_burst)) w_next_state = c_st_g1;
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // Output logic; memory port idles on M0 fields with writes disabled
    always_comb begin
        ack0    = w_beat0;
        ack1    = w_beat1;
        gnt     = {r_state == c_st_g1, r_state == c_st_g0};
        busy    = (r_state != c_st_idle);
        dm_addr = addr0;
        dm_be   = be0;
        dm_wd   = wd0;
        dm_we   = w_beat0 && we0 && !rst;
        if (r_state == c_st_g1) begin
            dm_addr = addr1;
            dm_be   = be1;
            dm_wd   = wd1;
            dm_we   = w_beat1 && we1 && !rst;
        end
    end

    // Grant history, burst counter and registered read return
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_beat_cnt <= 4'd0;
            r_rdata    <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_rvalid0 <= w_beat0 && !we0;
            r_rvalid1 <= w_beat1 && !we1;
            if ((w_beat0 && !we0) || (w_beat1 && !we1)) begin
                r_rdata <= dm_rd;
            end
            if ((r_state == c_st_idle) && (w_next_state != c_st_idle)) begin
                r_last     <= (w_next_state == c_st_g1);
                r_beat_cnt <= 4'd0;
            end else if (w_beat0 || w_beat1) begin
                r_beat_cnt <= w_cnt_inc[3:0];
            end
        end
    end

    assign rdata   = r_rdata;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Directed self-checking bench for dm_arbiter with a dm_4k model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [9:0]  addr0, addr1;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1;
    logic        ack0, ack1, rvalid0, rvalid1, busy, dm_we;
    logic [31:0] rdata, dm_wd, dm_rd;
    logic [1:0]  gnt;
    logic [9:0]  dm_addr;
    logic [3:0]  dm_be;

    logic [31:0] mem [0:1023];
    int          wr_cnt;
    int          n_cmp;
    int          n_err;

    dm_arbiter #(.AW(10), .DW(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .be0(be0), .wd0(wd0),
        .req1(req1), .we1(we1), .addr1(addr1), .be1(be1), .wd1(wd1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .gnt(gnt), .busy(busy),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_wd(dm_wd), .dm_we(dm_we),
        .dm_rd(dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dm_4k model: combinational read, byte-enabled write on the rising edge
    assign dm_rd = mem[dm_addr];
    always @(posedge clk) begin
        if (dm_we) begin
            wr_cnt <= wr_cnt + 1;
            for (int b = 0; b < 4; b++) begin
                if (dm_be[b]) mem[dm_addr][8*b +: 8] <= dm_wd[8*b +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One M0 beat from IDLE; captures the ack-cycle port view and the read return
    task automatic m0_beat(input logic w, input logic [9:0] a, input logic [3:0] b,
                           input logic [31:0] d, output logic ak, output logic dwe,
                           output logic [3:0] dbe, output logic rv, output logic [31:0] rd);
        req0 = 1'b1; we0 = w; addr0 = a; be0 = b; wd0 = d;
        tick();
        ak  = ack0;
        dwe = dm_we;
        dbe = dm_be;
        tick();
        req0 = 1'b0;
        rv = rvalid0;
        rd = rdata;
        tick();
    endtask

    initial begin
        logic        ak, dwe, rv;
        logic [3:0]  dbe;
        logic [31:0] rd;
        logic [17:0] exp0, exp1;
        int          w0;

        n_cmp = 0; n_err = 0; wr_cnt = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; be0 = '0; wd0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; be1 = '0; wd1 = '0;
        tick();
        tick();
        check("rst_gnt", gnt, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_ack", {ack1, ack0}, 2'b00);
        check("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        // 1: full write then read back
        req0 = 1'b1; we0 = 1'b1; #1;
        check("t1_idle_ack0", ack0, 0);
        req0 = 1'b0;
        w0 = wr_cnt;
        m0_beat(1'b1, 10'h010, 4'hF, 32'hDEADBEEF, ak, dwe, dbe, rv, rd);
        check("t1_wr_ack0", ak, 1);
        check("t1_wr_dmwe", dwe, 1);
        check("t1_wr_rvalid", rv, 0);
        check("t1_wr_once", wr_cnt - w0, 1);
        m0_beat(1'b0, 10'h010, 4'hF, 32'h0, ak, dwe, dbe, rv, rd);
        check("t1_rd_ack0", ak, 1);
        check("t1_rd_rvalid", rv, 1);
        check("t1_rd_rdata", rd, 32'hDEADBEEF);
        check("t1_rd_rvalid_drop", rvalid0, 0);

        // 2: contention from reset, then contention after an M0 grant
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 10'h001; addr1 = 10'h002;
        #1;
        check("t2_idle_gnt", gnt, 2'b00);
        tick();
        check("t2_first_gnt", gnt, 2'b01);
        check("t2_first_ack1", ack1, 0);
        tick();
        req0 = 0;
        tick();
        check("t2_turnaround", gnt, 2'b00);
        tick();
        check("t2_second_gnt", gnt, 2'b10);
        check("t2_second_ack1", ack1, 1);
        tick();
        req1 = 0;
        tick();
        m0_beat(1'b0, 10'h003, 4'hF, 32'h0, ak, dwe, dbe, rv, rd);
        req0 = 1; req1 = 1;
        tick();
        check("t2_rr_gnt", gnt, 2'b10);
        tick();
        req0 = 0; req1 = 0;
        tick();

        // 3: M0 streams 10 reads with M1 waiting; bursts capped at 4 beats
        exp0 = 18'h0DE1E;
        exp1 = 18'h00040;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 10'h010; addr1 = 10'h011;
        for (int c = 0; c < 18; c++) begin
            if (c == 7)  req1 = 0;
            if (c == 16) req0 = 0;
            #1;
            check($sformatf("t3_ack0_c%0d", c), ack0, exp0[c]);
            check($sformatf("t3_ack1_c%0d", c), ack1, exp1[c]);
            if (c == 2) check("t3_rdata_c2", {rvalid0, rdata}, {1'b1, 32'hDEADBEEF});
            tick();
        end

        // 4: byte-lane write merge
        m0_beat(1'b1, 10'h020, 4'hF, 32'h11223344, ak, dwe, dbe, rv, rd);
        m0_beat(1'b1, 10'h020, 4'b0010, 32'h0000AB00, ak, dwe, dbe, rv, rd);
        check("t4_dm_be", dbe, 4'b0010);
        check("t4_dm_we", dwe, 1);
        m0_beat(1'b0, 10'h020, 4'hF, 32'h0, ak, dwe, dbe, rv, rd);
        check("t4_readback", rd, 32'h1122AB44);

        // 5: reset lands on an M1 write beat
        req1 = 1; we1 = 1; addr1 = 10'h030; be1 = 4'hF; wd1 = 32'h00000055;
        tick();
        check("t5_ack1", ack1, 1);
        rst = 1;
        #1;
        check("t5_dmwe_rst", dm_we, 0);
        w0 = wr_cnt;
        tick();
        rst = 0; req1 = 0;
        #1;
        check("t5_gnt", gnt, 2'b00);
        check("t5_busy", busy, 0);
        check("t5_rvalid", {rvalid1, rvalid0}, 2'b00);
        check("t5_mem", mem[10'h030], 32'h0);
        check("t5_no_write", wr_cnt - w0, 0);

        // 6: M1 request withdrawn before its grant
        w0 = wr_cnt;
        req1 = 1; we1 = 1; addr1 = 10'h031; wd1 = 32'h12345678;
        tick();
        req1 = 0;
        #1;
        check("t6_gnt", gnt, 2'b10);
        check("t6_ack1", ack1, 0);
        check("t6_dmwe", dm_we, 0);
        tick();
        check("t6_idle", {busy, gnt}, 3'b000);
        check("t6_no_write", wr_cnt - w0, 0);
        check("t6_mem", mem[10'h031], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
